// File: rtl/fp64_to_fp32_narrowing_converter.sv
// Two-stage binary64 -> binary32 narrowing converter (fcvt.s.d) with
// valid/ready handshake on both sides and RISC-V accrued exception flags.
module fp64_to_fp32_narrowing_converter #(
    parameter int unsigned PIPE_STAGES   = 2,
    parameter logic [31:0] CANONICAL_NAN = 32'h7FC0_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [63:0] operand_i,
    input  logic [2:0]  rm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic [4:0]  fflags_o
);

    localparam int unsigned EXP64_W   = 11;
    localparam int unsigned MAN64_W   = 52;
    localparam int unsigned SIG_W     = 53;
    localparam int unsigned EXP_W     = 13;
    localparam int unsigned SHIFT_W   = 5;
    localparam int unsigned KEEP_W    = 24;
    localparam int unsigned EXT_W     = 79;
    localparam int unsigned FLAGS_W   = 5;

    localparam logic signed [EXP_W-1:0] REBIAS    = 13'sd896;
    localparam logic signed [EXP_W-1:0] SHIFT_MAX = 13'sd26;
    localparam logic signed [EXP_W-1:0] EXP_OVF   = 13'sd255;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [31:0] MAX_FINITE_MAG = 32'h7F7F_FFFF;
    localparam logic [31:0] INF_MAG        = 32'h7F80_0000;

    // Only the two-register pipeline is implemented.
    if (PIPE_STAGES != 2) begin : g_bad_pipe_stages
        $error("fp64_to_fp32_narrowing_converter: PIPE_STAGES must be 2");
    end

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_QNAN = 3'd4,
        CLS_SNAN = 3'd5
    } cls_e;

    // Rounding increment decision for a kept lsb, guard and sticky.
    function automatic logic f_round_up(
        input logic [2:0] rm,
        input logic       sign,
        input logic       lsb,
        input logic       guard,
        input logic       sticky
    );
        logic up;
        up = 1'b0;
        case (rm)
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = sign & (guard | sticky);
            RM_RUP:  up = ~sign & (guard | sticky);
            RM_RMM:  up = guard;
            default: up = guard & (sticky | lsb);
        endcase
        return up;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_en;
    logic r_s1_valid;
    logic r_s2_valid;

    assign w_en       = ~r_s2_valid | out_ready_i;
    assign in_ready_o = w_en;

    // ------------------------------------------------------------------
    // Stage 1: classify, rebias, form significand
    // ------------------------------------------------------------------
    logic [EXP64_W-1:0]       w_exp64;
    logic [MAN64_W-1:0]       w_man64;
    logic                     w_exp_zero;
    logic                     w_exp_ones;
    logic                     w_man_zero;
    cls_e                     w_class;
    logic signed [EXP_W-1:0]  w_e32;
    logic [SIG_W-1:0]         w_sig;

    assign w_exp64    = operand_i[62:52];
    assign w_man64    = operand_i[51:0];
    assign w_exp_zero = (w_exp64 == '0);
    assign w_exp_ones = &w_exp64;
    assign w_man_zero = (w_man64 == '0);
    assign w_e32      = $signed({2'b00, w_exp64}) - REBIAS;
    assign w_sig      = {~w_exp_zero, w_man64};

    // Decode the operand class from exponent/mantissa patterns.
    always_comb begin
        w_class = CLS_NORM;
        if (w_exp_zero) begin
            w_class = w_man_zero ? CLS_ZERO : CLS_SUB;
        end else if (w_exp_ones) begin
            if (w_man_zero) begin
                w_class = CLS_INF;
            end else if (w_man64[MAN64_W-1]) begin
                w_class = CLS_QNAN;
            end else begin
                w_class = CLS_SNAN;
            end
        end
    end

    logic                     r_s1_sign;
    cls_e                     r_s1_class;
    logic signed [EXP_W-1:0]  r_s1_exp;
    logic [SIG_W-1:0]         r_s1_sig;
    logic [2:0]               r_s1_rm;

    // Stage 1 register: capture unpacked operand on accept, hold on stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_class <= CLS_ZERO;
            r_s1_exp   <= '0;
            r_s1_sig   <= '0;
            r_s1_rm    <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid_i;
            if (in_valid_i) begin
                r_s1_sign  <= operand_i[63];
                r_s1_class <= w_class;
                r_s1_exp   <= w_e32;
                r_s1_sig   <= w_sig;
                r_s1_rm    <= rm_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: denormalising shift, round, pack
    // ------------------------------------------------------------------
    logic                     w_sub_path;
    logic signed [EXP_W-1:0]  w_shift_full;
    logic [SHIFT_W-1:0]       w_shamt;
    logic [EXT_W-1:0]         w_ext;
    logic [KEEP_W-1:0]        w_kept;
    logic                     w_guard;
    logic                     w_sticky;
    logic                     w_inexact;
    logic                     w_round_up;
    logic [KEEP_W:0]          w_rounded;
    logic signed [EXP_W-1:0]  w_exp_sum;
    logic                     w_overflow;
    logic                     w_ovf_to_inf;

    assign w_sub_path   = ~(r_s1_exp > 13'sd0);
    assign w_shift_full = 13'sd1 - r_s1_exp;

    // Denormalising shift amount: 1 - e32 when tiny, saturated so that
    // every bit ends up at or below the sticky position.
    always_comb begin
        w_shamt = '0;
        if (w_sub_path) begin
            if (w_shift_full > SHIFT_MAX) begin
                w_shamt = SHIFT_W'(26);
            end else begin
                w_shamt = w_shift_full[SHIFT_W-1:0];
            end
        end
    end

    // Extended window keeps shifted-out bits so they fold into sticky.
    assign w_ext      = {r_s1_sig, 26'b0} >> w_shamt;
    assign w_kept     = w_ext[78:55];
    assign w_guard    = w_ext[54];
    assign w_sticky   = |w_ext[53:0];
    assign w_inexact  = w_guard | w_sticky;
    assign w_round_up = f_round_up(r_s1_rm, r_s1_sign, w_kept[0], w_guard, w_sticky);
    assign w_rounded  = {1'b0, w_kept} + (KEEP_W+1)'(w_round_up);

    // A mantissa carry-out bumps the exponent; the mantissa field is zero then.
    assign w_exp_sum  = r_s1_exp + $signed({12'b0, w_rounded[KEEP_W]});
    assign w_overflow = ~w_sub_path & (w_exp_sum >= EXP_OVF);

    // Tininess is judged after rounding at full 24-bit precision with an
    // unbounded exponent: only e32 == 0 can escape, by carrying to 2^-126.
    logic [KEEP_W-1:0] w_kept_ub;
    logic              w_guard_ub;
    logic              w_sticky_ub;
    logic              w_up_ub;
    logic              w_carry_ub;
    logic              w_tiny;

    assign w_kept_ub   = r_s1_sig[52:29];
    assign w_guard_ub  = r_s1_sig[28];
    assign w_sticky_ub = |r_s1_sig[27:0];
    assign w_up_ub     = f_round_up(r_s1_rm, r_s1_sign, w_kept_ub[0], w_guard_ub, w_sticky_ub);
    assign w_carry_ub  = (&w_kept_ub) & w_up_ub;
    assign w_tiny      = (r_s1_exp < 13'sd0) | ((r_s1_exp == 13'sd0) & ~w_carry_ub);

    // Overflow direction: infinity unless the mode rounds toward zero for this sign.
    always_comb begin
        w_ovf_to_inf = 1'b1;
        case (r_s1_rm)
            RM_RTZ:  w_ovf_to_inf = 1'b0;
            RM_RDN:  w_ovf_to_inf = r_s1_sign;
            RM_RUP:  w_ovf_to_inf = ~r_s1_sign;
            default: w_ovf_to_inf = 1'b1;
        endcase
    end

    logic [31:0]        w_s2_result;
    logic [FLAGS_W-1:0] w_s2_flags;

    // Final packing and flag generation per operand class.
    always_comb begin
        w_s2_result = '0;
        w_s2_flags  = '0;
        case (r_s1_class)
            CLS_ZERO: begin
                w_s2_result = {r_s1_sign, 31'b0};
            end
            CLS_INF: begin
                w_s2_result = {r_s1_sign, INF_MAG[30:0]};
            end
            CLS_QNAN: begin
                w_s2_result = CANONICAL_NAN;
            end
            CLS_SNAN: begin
                w_s2_result = CANONICAL_NAN;
                w_s2_flags  = 5'b10000;
            end
            default: begin
                if (w_overflow) begin
                    w_s2_result = w_ovf_to_inf ? {r_s1_sign, INF_MAG[30:0]}
                                               : {r_s1_sign, MAX_FINITE_MAG[30:0]};
                    w_s2_flags  = 5'b00101;
                end else begin
                    if (w_sub_path) begin
                        // Leading bit reaching bit 23 means it rounded up to 2^-126.
                        w_s2_result = {r_s1_sign, 7'b0, w_rounded[23], w_rounded[22:0]};
                    end else begin
                        w_s2_result = {r_s1_sign, w_exp_sum[7:0], w_rounded[22:0]};
                    end
                    w_s2_flags = {3'b000, w_tiny & w_inexact, w_inexact};
                end
            end
        endcase
    end

    logic [31:0]        r_s2_result;
    logic [FLAGS_W-1:0] r_s2_flags;

    // Stage 2 register: output holding stage, frozen while the consumer stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_flags  <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result <= w_s2_result;
                r_s2_flags  <= w_s2_flags;
            end
        end
    end

    assign out_valid_o = r_s2_valid;
    assign result_o    = r_s2_result;
    assign fflags_o    = r_s2_flags;

endmodule

// File: tb/tb_fp64_to_fp32_narrowing_converter.sv
// Self-checking bench for the binary64 -> binary32 narrowing converter.
module tb_fp64_to_fp32_narrowing_converter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] operand_i;
    logic [2:0]  rm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;

    fp64_to_fp32_narrowing_converter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .operand_i   (operand_i),
        .rm_i        (rm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .fflags_o    (fflags_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;

    logic [36:0] exp_q[$];
    logic        prev_hold;
    logic [36:0] held;

    typedef struct {
        logic [63:0] op;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Round an integer significand m right by sh bits under the given mode.
    function automatic longint rnd_q(input longint m, input int sh, input logic [2:0] rm,
                                     input logic sgn, output bit inx);
        longint q, r, half;
        bit gt, eq, up;
        if (sh <= 0) begin
            inx = 1'b0;
            return m <<< (-sh);
        end
        if (sh >= 62) begin
            q = 0; inx = (m != 0); gt = 1'b0; eq = 1'b0;
        end else begin
            q    = m >>> sh;
            r    = m - (q <<< sh);
            half = 64'sd1 <<< (sh - 1);
            gt   = (r > half);
            eq   = (r == half);
            inx  = (r != 0);
        end
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = sgn && inx;
            3'd3:    up = !sgn && inx;
            3'd4:    up = gt || eq;
            default: up = gt || (eq && q[0]);
        endcase
        return q + (up ? 64'sd1 : 64'sd0);
    endfunction

    // Reference: value = m * 2^E exactly; round to the binary32 quantum.
    function automatic void ref_model(input logic [63:0] op, input logic [2:0] rm,
                                      output logic [31:0] res, output logic [4:0] fl);
        logic   s;
        int     e, E, L, msb, qexp, biased;
        longint m, q, qu;
        bit     inx, inxu, tiny, to_inf;
        s = op[63];
        e = int'(op[62:52]);
        res = 32'h0;
        fl  = 5'h0;
        if (e == 2047) begin
            if (op[51:0] == 52'h0) res = {s, 8'hFF, 23'h0};
            else begin
                res = 32'h7FC00000;
                fl  = op[51] ? 5'h00 : 5'h10;
            end
            return;
        end
        if (e == 0 && op[51:0] == 52'h0) begin
            res = {s, 31'h0};
            return;
        end
        m = longint'({12'h0, op[51:0]});
        if (e != 0) m = m + (64'sd1 <<< 52);
        E = ((e == 0) ? 1 : e) - 1075;
        msb = 0;
        for (int i = 0; i < 53; i++) if (m[i]) msb = i;
        L = E + msb;
        qexp = ((L > -126) ? L : -126) - 23;
        q = rnd_q(m, qexp - E, rm, s, inx);
        if (q == (64'sd1 <<< 24)) begin
            q = 64'sd1 <<< 23;
            qexp++;
        end
        qu = rnd_q(m, msb - 23, rm, s, inxu);
        tiny = (((qu == (64'sd1 <<< 24)) ? L + 1 : L) < -126);
        fl = {3'b000, tiny && inx, inx};
        if (q >= (64'sd1 <<< 23)) begin
            biased = qexp + 23 + 127;
            if (biased >= 255) begin
                to_inf = (rm == 3'd1) ? 1'b0 : (rm == 3'd2) ? s : (rm == 3'd3) ? !s : 1'b1;
                res = to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
                fl  = 5'h05;
            end else begin
                res = {s, biased[7:0], q[22:0]};
            end
        end else begin
            res = {s, 8'h00, q[22:0]};
        end
    endfunction

    // One cycle of streaming: inputs already driven at this negedge.
    task automatic tick(output bit acc);
        logic [36:0] e;
        logic [31:0] r;
        logic [4:0]  f;
        #1;
        if (prev_hold) begin
            chk("hold_valid", out_valid_o, 1);
            chk("hold_data", {result_o, fflags_o}, held);
        end
        prev_hold = out_valid_o && !out_ready_i;
        held = {result_o, fflags_o};
        if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_output actual=%0h expected=none", result_o);
            end else begin
                e = exp_q.pop_front();
                chk("stream_res", result_o, e[36:5]);
                chk("stream_flags", fflags_o, e[4:0]);
                n_out++;
            end
        end
        acc = in_valid_i && in_ready_o;
        if (acc) begin
            ref_model(operand_i, rm_i, r, f);
            exp_q.push_back({r, f});
        end
        @(negedge clk_i);
    endtask

    // Single directed vector on an idle pipeline, also checks latency.
    task automatic run_vec(input int idx);
        int n;
        in_valid_i  = 1'b1;
        operand_i   = vecs[idx].op;
        rm_i        = vecs[idx].rm;
        out_ready_i = 1'b1;
        #1;
        chk($sformatf("vec%0d_in_ready", idx), in_ready_o, 1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        n = 1;
        while (!out_valid_o && n < 8) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk($sformatf("vec%0d_latency", idx), n, 2);
        chk($sformatf("vec%0d_res", idx), result_o, vecs[idx].res);
        chk($sformatf("vec%0d_flags", idx), fflags_o, vecs[idx].fl);
        @(negedge clk_i);
    endtask

    function automatic logic [63:0] rand_op();
        logic [51:0] m;
        logic [10:0] e;
        int k;
        m = 52'({$urandom(), $urandom()});
        k = $urandom_range(0, 9);
        case (k)
            0: begin e = 11'd0; if ($urandom_range(0, 3) == 0) m = '0; end
            1: begin e = 11'h7FF; if ($urandom_range(0, 3) == 0) m = '0; end
            2: e = 11'(870 + $urandom_range(0, 30));
            3: e = 11'(1140 + $urandom_range(0, 20));
            4: begin e = 11'(872 + $urandom_range(0, 280)); m[28:0] = 29'h10000000; end
            5: begin e = 11'(872 + $urandom_range(0, 280)); m[51:29] = '1; end
            6: begin e = 11'd896; m[51:29] = '1; end
            default: e = 11'(872 + $urandom_range(0, 280));
        endcase
        return {1'($urandom_range(0, 1)), e, m};
    endfunction

    logic [63:0] bp_ops[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bit acc;
        int idx, guard, out_base;

        vecs[0]  = '{64'h3FF0000000000000, 3'd0, 32'h3F800000, 5'h00};
        vecs[1]  = '{64'h3FF0000010000000, 3'd0, 32'h3F800000, 5'h01};
        vecs[2]  = '{64'h3FF0000010000000, 3'd3, 32'h3F800001, 5'h01};
        vecs[3]  = '{64'h3FF0000010000000, 3'd4, 32'h3F800001, 5'h01};
        vecs[4]  = '{64'h7E37E43C8800759C, 3'd0, 32'h7F800000, 5'h05};
        vecs[5]  = '{64'h7E37E43C8800759C, 3'd1, 32'h7F7FFFFF, 5'h05};
        vecs[6]  = '{64'hFE37E43C8800759C, 3'd3, 32'hFF7FFFFF, 5'h05};
        vecs[7]  = '{64'h7FF0000000000001, 3'd0, 32'h7FC00000, 5'h10};
        vecs[8]  = '{64'h7FF8000000000000, 3'd0, 32'h7FC00000, 5'h00};
        vecs[9]  = '{64'hFFF0000000000000, 3'd0, 32'hFF800000, 5'h00};
        vecs[10] = '{64'h36A0000000000000, 3'd0, 32'h00000001, 5'h00};
        vecs[11] = '{64'h3690000000000000, 3'd0, 32'h00000000, 5'h03};
        vecs[12] = '{64'h3690000000000000, 3'd3, 32'h00000001, 5'h03};
        vecs[13] = '{64'h8000000000000000, 3'd0, 32'h80000000, 5'h00};
        vecs[14] = '{64'hFE37E43C8800759C, 3'd2, 32'hFF800000, 5'h05};
        vecs[15] = '{64'h47EFFFFFF0000000, 3'd0, 32'h7F800000, 5'h05};
        vecs[16] = '{64'h47EFFFFFF0000000, 3'd1, 32'h7F7FFFFF, 5'h01};
        vecs[17] = '{64'h3FFFFFFFF0000000, 3'd0, 32'h40000000, 5'h01};
        vecs[18] = '{64'h380FFFFFFFFFFFFF, 3'd0, 32'h00800000, 5'h01};
        vecs[19] = '{64'h380FFFFFFFFFFFFF, 3'd1, 32'h007FFFFF, 5'h03};
        vecs[20] = '{64'h0000000000000001, 3'd3, 32'h00000001, 5'h03};
        vecs[21] = '{64'h0000000000000001, 3'd0, 32'h00000000, 5'h03};
        vecs[22] = '{64'h8000000000000001, 3'd2, 32'h80000001, 5'h03};
        vecs[23] = '{64'h3FF0000010000000, 3'd5, 32'h3F800000, 5'h01};

        bp_ops[0] = 64'h3FF0000000000000;
        bp_ops[1] = 64'h3FF8000000000000;
        bp_ops[2] = 64'hC000000000000000;
        bp_ops[3] = 64'h3FF0000010000000;

        rst_i = 1'b1; in_valid_i = 1'b0; operand_i = '0; rm_i = '0; out_ready_i = 1'b0;
        prev_hold = 1'b0; held = '0;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_fflags", fflags_o, 0);
        rst_i = 1'b0;
        #1;
        chk("rst_in_ready", in_ready_o, 1);
        @(negedge clk_i);

        // Directed vectors
        for (int i = 0; i < NV; i++) run_vec(i);

        // Backpressure: out_ready held low, only two operands fit
        out_ready_i = 1'b0;
        idx = 0;
        out_base = n_out;
        for (int c = 0; c < 4; c++) begin
            in_valid_i = 1'b1;
            operand_i  = bp_ops[idx];
            rm_i       = 3'd0;
            tick(acc);
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 2);
        #1;
        chk("bp_in_ready", in_ready_o, 0);
        chk("bp_out_valid", out_valid_o, 1);
        out_ready_i = 1'b1;
        guard = 0;
        while (idx < 4 && guard < 20) begin
            in_valid_i = 1'b1;
            operand_i  = bp_ops[idx];
            tick(acc);
            if (acc) idx++;
            guard++;
        end
        in_valid_i = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick(acc);
            guard++;
        end
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_out_count", n_out - out_base, 4);

        // Reset mid-stream
        out_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid_i = 1'b1;
            operand_i  = bp_ops[c];
            tick(acc);
        end
        in_valid_i = 1'b0;
        #1;
        chk("pre_rst_valid", out_valid_o, 1);
        rst_i = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid_o, 0);
        chk("midrst_result", result_o, 0);
        exp_q.delete();
        prev_hold = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("post_rst_no_stale", out_valid_o, 0);
            tick(acc);
        end
        run_vec(0);

        // Randomized streaming against the reference model
        for (int c = 0; c < 3000; c++) begin
            in_valid_i  = ($urandom_range(0, 9) < 7);
            out_ready_i = ($urandom_range(0, 9) < 7);
            operand_i   = rand_op();
            rm_i        = 3'($urandom_range(0, 7));
            tick(acc);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick(acc);
            guard++;
        end
        chk("rand_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp64_to_fp32_narrowing_converter.md
Name: fp64_to_fp32_narrowing_converter

Overview:
- Pipelined IEEE 754-2019 binary64 to binary32 narrowing converter (fcvt.s.d) for the vector floating-point functional unit.
- Takes a packed double-precision operand, unpacks sign, exponent and mantissa, rebiases, and rounds into a packed single-precision result.
- Produces RISC-V accrued exception flags for each result.
- Sits between the vector register-file operand path and the FP writeback path, using a valid/ready handshake on both sides.

Parameters:
- PIPE_STAGES, 2, fixed number of register stages from input to output (only value 2 is supported).
- CANONICAL_NAN, 32'h7FC0_0000, binary32 value returned for any NaN input.

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- in_valid_i  input  1  operand valid.
- in_ready_o  output  1  converter can accept an operand this cycle.
- operand_i  input  64  binary64 operand: sign [63], exponent [62:52], mantissa [51:0].
- rm_i  input  3  rounding mode, sampled with the operand.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- result_o  output  32  binary32 result: sign [31], exponent [30:23], mantissa [22:0].
- fflags_o  output  5  exception flags {NV,DZ,OF,UF,NX}, bit 4 down to bit 0.

Behaviour:
- Reset (asynchronous, active-high): both stage valids clear, out_valid_o=0, result_o=0, fflags_o=0. in_ready_o=1 once reset is released. Any in-flight operands are discarded.
- Handshake:
  - A transfer occurs when a valid is high together with its ready.
  - Pipeline enable is en = !s2_valid || out_ready_i; in_ready_o = en.
  - When en=0, all stages hold their data.
  - Latency is exactly 2 cycles from input accept to out_valid_o while out_ready_i=1. Throughput is 1 per cycle.
  - in_ready_o may depend combinationally on out_ready_i.
  - result_o and fflags_o stay stable while out_valid_o=1 and out_ready_i=0.
- Stage 1 (classify and rebias):
  - Classify the input as zero, subnormal, normal, infinity, qNaN or sNaN.
  - Signed unbounded exponent: e32 = e64 - 896. Hold it in a 13-bit signed register.
  - Form the 53-bit significand with the implicit bit (0 for subnormals).
- Stage 2 (round and pack):
  - Keep 24 significant bits. Guard is the next bit; sticky is the OR of all remaining bits.
  - If e32 <= 0, right-shift the significand by 1 - e32 first (shift saturates at 26; lost bits feed sticky) and pack as subnormal.
  - Input subnormals are always tiny and yield zero or min-subnormal per rounding mode.
- Rounding modes:
  - 000 RNE: ties to even.
  - 001 RTZ: truncate.
  - 010 RDN: round toward negative infinity.
  - 011 RUP: round toward positive infinity.
  - 100 RMM: ties away from zero.
  - 101-111: treated as RNE, no extra flag.
- Mantissa carry-out after rounding increments the exponent. A subnormal that rounds up to 2^-126 becomes normal.
- Overflow (rounded exponent >= 255):
  - OF and NX set.
  - Result is infinity for RNE and RMM; max finite 0x7F7FFFFF for RTZ; sign-dependent for RDN/RUP (toward-infinity direction gives infinity, the other gives ±max finite).
- Underflow: UF is set when the result is tiny after rounding (unbounded exponent, 24-bit precision, |x| < 2^-126) AND inexact. NX is set on any precision loss.
- Special inputs:
  - Infinity: ±infinity, no flags.
  - Zero: ±0, no flags.
  - qNaN: CANONICAL_NAN, no flags.
  - sNaN: CANONICAL_NAN with NV.
- DZ is always 0.
- Sign is preserved for all non-NaN results, including zero results from underflow.

Test Plan:
- 0x3FF0000000000000 (1.0), RNE, out_ready_i=1 -> result 0x3F800000, flags 0, out_valid_o asserted exactly 2 cycles after accept.
- Halfway tie 0x3FF0000010000000:
  - RNE -> 0x3F800000, flags 0x01.
  - RUP -> 0x3F800001, flags 0x01.
  - RMM -> 0x3F800001, flags 0x01.
- Overflow 0x7E37E43C8800759C (1e300):
  - RNE -> 0x7F800000, flags 0x05.
  - RTZ -> 0x7F7FFFFF, flags 0x05.
  - Sign bit set with RUP -> 0xFF7FFFFF.
- Special inputs:
  - sNaN 0x7FF0000000000001 -> 0x7FC00000, flags 0x10.
  - qNaN 0x7FF8000000000000 -> 0x7FC00000, flags 0.
  - 0xFFF0000000000000 -> 0xFF800000, flags 0.
- Subnormal boundary:
  - 0x36A0000000000000 (2^-149) -> 0x00000001, flags 0.
  - 0x3690000000000000 (2^-150), RNE -> 0x00000000, flags 0x03; same input with RUP -> 0x00000001, flags 0x03.
- Backpressure and reset:
  - Stream 4 back-to-back operands while holding out_ready_i=0 -> 2 accepted, then in_ready_o=0; results are delivered in order with no loss or duplication once out_ready_i=1.
  - Asserting rst_i mid-stream -> out_valid_o=0 in the same cycle, no stale result after release.
